// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous instruction
// memory and captures the returned word into the IF/ID pipeline register.
// Redirects resolved in ID (branch / jump / jump-register) come back through
// pc_src. The hazard unit supplies stall and flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_off,
    input  logic [25:0] jmp_idx,
    input  logic [31:0] jr_target,
    output logic [31:0] inst_adr,
    input  logic [31:0] inst_in,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_cnt
);

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_JR     = 2'b11;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] redirect_pc;

    // The memory is asynchronous, so the PC register addresses it directly.
    assign inst_adr = pc;

    // Sequential successor; wraps modulo 2^32.
    assign pc4 = pc + 32'd4;

    // Redirect targets are relative to the instruction now sitting in ID,
    // hence ifid_pc4 rather than the fetch-side pc4.
    always_comb begin
        redirect_pc = pc4;
        case (pc_src)
            SRC_SEQ:    redirect_pc = pc4;
            SRC_BRANCH: redirect_pc = ifid_pc4 + {branch_off[29:0], 2'b00};
            SRC_JUMP:   redirect_pc = {ifid_pc4[31:28], jmp_idx, 2'b00};
            SRC_JR:     redirect_pc = jr_target;
            default:    redirect_pc = pc4;
        endcase
    end

    // PC, IF/ID register and fetch counter.
    // Priority: rst > stall > redirect/flush > normal fetch.
    // A redirect always bubbles IF/ID: the word fetched this cycle is on the
    // wrong path. Under stall, flush still bubbles IF/ID while the PC holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_inst  <= NOP_INST;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            fetch_cnt  <= 32'd0;
        end else if (stall) begin
            if (flush) begin
                ifid_inst  <= NOP_INST;
                ifid_pc4   <= 32'd0;
                ifid_valid <= 1'b0;
            end
        end else if (pc_src != SRC_SEQ) begin
            pc         <= redirect_pc;
            ifid_inst  <= NOP_INST;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            pc <= pc4;
            if (flush) begin
                ifid_inst  <= NOP_INST;
                ifid_pc4   <= 32'd0;
                ifid_valid <= 1'b0;
            end else begin
                ifid_inst  <= inst_in;
                ifid_pc4   <= pc4;
                ifid_valid <= 1'b1;
                fetch_cnt  <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The instruction memory is modelled as
// word = address + 0x2000_0000, so expected words are easy to hand-compute.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_off;
    logic [25:0] jmp_idx;
    logic [31:0] jr_target;
    logic [31:0] inst_adr;
    logic [31:0] inst_in;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_cnt;

    int total;
    int bad;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
        .branch_off(branch_off), .jmp_idx(jmp_idx), .jr_target(jr_target),
        .inst_adr(inst_adr), .inst_in(inst_in), .ifid_inst(ifid_inst),
        .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .fetch_cnt(fetch_cnt)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign inst_in = inst_adr + 32'h2000_0000;

    // advance one edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic [1:0] src);
        stall  = s;
        flush  = f;
        pc_src = src;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(1'b0, 1'b0, 2'b00);
        branch_off = 32'd0; jmp_idx = 26'd0; jr_target = 32'd0;
        step(); step();
        total++; if (inst_adr !== 32'h0) begin bad++; $display("FAIL rst_adr got=%h exp=%h", inst_adr, 32'h0); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
        total++; if (ifid_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=%h", ifid_inst, 32'h0); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
        total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", fetch_cnt); end
    endtask

    task automatic test_straight();
        exp_q.push_back(32'd4); exp_q.push_back(32'd8); exp_q.push_back(32'd12);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = exp_q.pop_front();
            total++; if (inst_adr !== exp_v) begin bad++; $display("FAIL seq_adr%0d got=%h exp=%h", i, inst_adr, exp_v); end
        end
        total++; if (ifid_pc4 !== 32'd12) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", ifid_pc4, 32'd12); end
        total++; if (ifid_inst !== 32'h2000_0008) begin bad++; $display("FAIL seq_inst got=%h exp=%h", ifid_inst, 32'h2000_0008); end
        total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", ifid_valid); end
        total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
    endtask

    task automatic test_branch();
        // four more sequential fetches: pc 28, ifid_pc4 28, count 7
        for (int i = 0; i < 4; i++) step();
        total++; if (ifid_pc4 !== 32'd28) begin bad++; $display("FAIL br_setup got=%h exp=%h", ifid_pc4, 32'd28); end
        branch_off = -32'sd5;
        drive(1'b0, 1'b0, 2'b01);
        step();
        total++; if (inst_adr !== 32'd8) begin bad++; $display("FAIL br_adr got=%h exp=%h", inst_adr, 32'd8); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL br_bubble got=%b exp=0", ifid_valid); end
        total++; if (ifid_inst !== 32'h0) begin bad++; $display("FAIL br_nop got=%h exp=%h", ifid_inst, 32'h0); end
        total++; if (fetch_cnt !== 32'd7) begin bad++; $display("FAIL br_cnt got=%0d exp=7", fetch_cnt); end
        drive(1'b0, 1'b0, 2'b00);
        step();
        total++; if (ifid_inst !== 32'h2000_0008) begin bad++; $display("FAIL br_inst got=%h exp=%h", ifid_inst, 32'h2000_0008); end
        total++; if (ifid_pc4 !== 32'd12) begin bad++; $display("FAIL br_pc4 got=%h exp=%h", ifid_pc4, 32'd12); end
        total++; if (fetch_cnt !== 32'd8) begin bad++; $display("FAIL br_cnt2 got=%0d exp=8", fetch_cnt); end
    endtask

    task automatic test_jump();
        // reach ifid_pc4 = 0x1000_0010 via jr to 0x1000_000C then one fetch
        jr_target = 32'h1000_000C;
        drive(1'b0, 1'b0, 2'b11);
        step();
        drive(1'b0, 1'b0, 2'b00);
        step();
        total++; if (ifid_pc4 !== 32'h1000_0010) begin bad++; $display("FAIL j_setup got=%h exp=%h", ifid_pc4, 32'h1000_0010); end
        jmp_idx = 26'h40;
        drive(1'b0, 1'b0, 2'b10);
        step();
        total++; if (inst_adr !== 32'h1000_0100) begin bad++; $display("FAIL j_adr got=%h exp=%h", inst_adr, 32'h1000_0100); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL j_bubble got=%b exp=0", ifid_valid); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL j_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
        jr_target = 32'h0000_0020;
        drive(1'b0, 1'b0, 2'b11);
        step();
        total++; if (inst_adr !== 32'h20) begin bad++; $display("FAIL jr_adr got=%h exp=%h", inst_adr, 32'h20); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL jr_bubble got=%b exp=0", ifid_valid); end
        total++; if (fetch_cnt !== 32'd9) begin bad++; $display("FAIL jr_cnt got=%0d exp=9", fetch_cnt); end
    endtask

    task automatic test_stall();
        // jr to 8, fetch once: pc 12, IF/ID holds word @8
        jr_target = 32'd8;
        drive(1'b0, 1'b0, 2'b11);
        step();
        drive(1'b0, 1'b0, 2'b00);
        step();
        branch_off = -32'sd5;
        drive(1'b1, 1'b0, 2'b01);
        step(); step();
        total++; if (inst_adr !== 32'd12) begin bad++; $display("FAIL st_adr got=%h exp=%h", inst_adr, 32'd12); end
        total++; if (ifid_inst !== 32'h2000_0008) begin bad++; $display("FAIL st_inst got=%h exp=%h", ifid_inst, 32'h2000_0008); end
        total++; if (ifid_pc4 !== 32'd12) begin bad++; $display("FAIL st_pc4 got=%h exp=%h", ifid_pc4, 32'd12); end
        total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%b exp=1", ifid_valid); end
        total++; if (fetch_cnt !== 32'd10) begin bad++; $display("FAIL st_cnt got=%0d exp=10", fetch_cnt); end
        drive(1'b1, 1'b1, 2'b01);
        step();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL stfl_valid got=%b exp=0", ifid_valid); end
        total++; if (inst_adr !== 32'd12) begin bad++; $display("FAIL stfl_adr got=%h exp=%h", inst_adr, 32'd12); end
        total++; if (fetch_cnt !== 32'd10) begin bad++; $display("FAIL stfl_cnt got=%0d exp=10", fetch_cnt); end
        drive(1'b0, 1'b0, 2'b00);
        step();
        total++; if (ifid_inst !== 32'h2000_000C) begin bad++; $display("FAIL rel_inst got=%h exp=%h", ifid_inst, 32'h2000_000C); end
        total++; if (fetch_cnt !== 32'd11) begin bad++; $display("FAIL rel_cnt got=%0d exp=11", fetch_cnt); end
        // flush alone: pc advances, bubble, count holds
        drive(1'b0, 1'b1, 2'b00);
        step();
        total++; if (inst_adr !== 32'd20) begin bad++; $display("FAIL fl_adr got=%h exp=%h", inst_adr, 32'd20); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", ifid_valid); end
        total++; if (fetch_cnt !== 32'd11) begin bad++; $display("FAIL fl_cnt got=%0d exp=11", fetch_cnt); end
    endtask

    task automatic test_wrap_reset();
        jr_target = 32'hFFFF_FFFC;
        drive(1'b0, 1'b0, 2'b11);
        step();
        drive(1'b0, 1'b0, 2'b00);
        step();
        total++; if (inst_adr !== 32'h0) begin bad++; $display("FAIL wr_adr got=%h exp=%h", inst_adr, 32'h0); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL wr_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
        total++; if (ifid_inst !== 32'h1FFF_FFFC) begin bad++; $display("FAIL wr_inst got=%h exp=%h", ifid_inst, 32'h1FFF_FFFC); end
        total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL wr_valid got=%b exp=1", ifid_valid); end
        total++; if (fetch_cnt !== 32'd12) begin bad++; $display("FAIL wr_cnt got=%0d exp=12", fetch_cnt); end
        // one more fetch to get a nonzero pc, then reset during a jump
        step();
        jmp_idx = 26'h3;
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b10);
        step();
        total++; if (inst_adr !== 32'h0) begin bad++; $display("FAIL rr_adr got=%h exp=%h", inst_adr, 32'h0); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rr_valid got=%b exp=0", ifid_valid); end
        total++; if (ifid_inst !== 32'h0) begin bad++; $display("FAIL rr_inst got=%h exp=%h", ifid_inst, 32'h0); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL rr_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
        total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL rr_cnt got=%0d exp=0", fetch_cnt); end
        // reset while stalled, after a few fetches
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00);
        step(); step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b00);
        step();
        total++; if (inst_adr !== 32'h0) begin bad++; $display("FAIL rs_adr got=%h exp=%h", inst_adr, 32'h0); end
        total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL rs_cnt got=%0d exp=0", fetch_cnt); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_straight();
        test_branch();
        test_jump();
        test_stall();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
